// File: rtl/sram_pkg.sv
// Shared SRAM geometry and loader state type for the background frame path.
package sram_pkg;

  localparam int SRAM_ADDR_COUNT = 20;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int FRAME_WORDS     = 640 * 480;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/sram_bg_loader.sv
// Background frame loader: packs byte pairs (low byte first) into 16-bit
// words and writes them to consecutive SRAM addresses, holding the write
// strobe for WRITE_CYCLES clocks per word.
//
// state | meaning
// IDLE  | waiting for i_start, SRAM owned by the frame decoder
// LO    | accepting the low byte of the next word
// HI    | accepting the high byte of the next word
// WRITE | strobe active, addr/data held stable
// DONE  | whole frame written, waiting for i_start to re-arm
module sram_bg_loader
  import sram_pkg::*;
#(
  parameter int NUM_WORDS    = FRAME_WORDS,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [7:0]                 i_byte,
  input  logic                       i_byte_valid,
  output logic                       o_byte_ready,
  output logic                       o_sram_writing,
  output logic [SRAM_ADDR_COUNT-1:0] o_sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] o_sram_data,
  output logic                       o_done
);

  localparam logic [SRAM_ADDR_COUNT-1:0] LAST_COUNT = SRAM_ADDR_COUNT'(NUM_WORDS - 1);
  localparam logic [SRAM_ADDR_COUNT-1:0] ONE_WORD   = SRAM_ADDR_COUNT'(1);
  localparam logic [2:0]                 TIMER_LOAD = 3'(WRITE_CYCLES - 1);

  loader_state_t                state_q, state_d;
  logic [SRAM_ADDR_COUNT-1:0]   addr_q, addr_d;
  logic [SRAM_ADDR_COUNT-1:0]   count_q, count_d;
  logic [SRAM_DATA_WIDTH-1:0]   data_q, data_d;
  logic [2:0]                   timer_q, timer_d;

  logic strobe_end;
  assign strobe_end = (timer_q == 3'd0);

  // State and datapath registers, cleared asynchronously so a mid-load
  // reset releases the SRAM immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
      timer_q <= timer_d;
    end
  end

  // Next-state: i_start is only honoured from IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = LO;
      LO:      if (i_byte_valid) state_d = HI;
      HI:      if (i_byte_valid) state_d = WRITE;
      WRITE:   if (strobe_end) state_d = (count_q == LAST_COUNT) ? DONE : LO;
      DONE:    if (i_start) state_d = LO;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: byte capture, strobe down-counter, address/word advance.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    data_d  = data_q;
    timer_d = timer_q;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          addr_d  = '0;
          count_d = '0;
        end
      end
      LO: begin
        if (i_byte_valid) data_d[7:0] = i_byte;
      end
      HI: begin
        if (i_byte_valid) begin
          data_d[15:8] = i_byte;
          timer_d      = TIMER_LOAD;
        end
      end
      WRITE: begin
        if (strobe_end) begin
          addr_d  = addr_q + ONE_WORD;
          count_d = count_q + ONE_WORD;
        end else begin
          timer_d = timer_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state only, so they follow reset without a clock.
  always_comb begin
    o_byte_ready   = 1'b0;
    o_sram_writing = 1'b0;
    o_done         = 1'b0;
    case (state_q)
      LO, HI:  o_byte_ready   = 1'b1;
      WRITE:   o_sram_writing = 1'b1;
      DONE:    o_done         = 1'b1;
      default: ;
    endcase
  end

  assign o_sram_addr = addr_q;
  assign o_sram_data = data_q;

endmodule

// File: tb/tb_sram_bg_loader.sv
// Scoreboard bench for sram_bg_loader with a 4-word frame.
module tb_sram_bg_loader;

  localparam int NW = 4;
  localparam int WC = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready;
  logic        o_sram_writing;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_data;
  logic        o_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    bit          last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frame_bytes [8];
  bit         b2b = 1'b0;

  sram_bg_loader #(.NUM_WORDS(NW), .WRITE_CYCLES(WC)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_byte         (i_byte),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .o_sram_writing (o_sram_writing),
    .o_sram_addr    (o_sram_addr),
    .o_sram_data    (o_sram_data),
    .o_done         (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Concurrent protocol properties on the SRAM strobe.
  a_no_ready_while_writing: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(o_sram_writing && o_byte_ready))
    else begin errors++; $display("FAIL assert_ready_during_write at %0t", $time); end

  a_stable_strobe: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (o_sram_writing && $past(o_sram_writing)) |-> ($stable(o_sram_addr) && $stable(o_sram_data)))
    else begin errors++; $display("FAIL assert_strobe_stability at %0t", $time); end

  // Monitor: pops an expectation at each strobe start, checks strobe length,
  // stability and the done flag one cycle after the strobe.
  initial begin : monitor
    bit          prev_w = 1'b0;
    int          slen = 0;
    logic [19:0] cap_a = '0;
    logic [15:0] cap_d = '0;
    bit          cur_last = 1'b0;
    bit          have_prev = 1'b0;
    logic [19:0] prev_addr = '0;
    time         prev_t = 0;
    exp_t        e;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        exp_q.delete();
        prev_w = 1'b0;
        have_prev = 1'b0;
        continue;
      end
      if (o_sram_writing) begin
        check("ready_low_in_write", {31'd0, o_byte_ready}, 32'd0);
        if (!prev_w) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe: addr 0x%0h data 0x%0h, none expected", o_sram_addr, o_sram_data);
            cur_last = 1'b0;
          end else begin
            e = exp_q.pop_front();
            check("write_addr", {12'd0, o_sram_addr}, {12'd0, e.addr});
            check("write_data", {16'd0, o_sram_data}, {16'd0, e.data});
            cur_last = e.last;
          end
          check("done_low_in_load", {31'd0, o_done}, 32'd0);
          if (b2b && have_prev && o_sram_addr == prev_addr + 20'd1)
            check("b2b_word_period", 32'($time - prev_t), 32'((2 + WC) * 10));
          have_prev = 1'b1;
          prev_addr = o_sram_addr;
          prev_t    = $time;
          cap_a = o_sram_addr;
          cap_d = o_sram_data;
          slen  = 1;
        end else begin
          slen++;
          check("strobe_addr_stable", {12'd0, o_sram_addr}, {12'd0, cap_a});
          check("strobe_data_stable", {16'd0, o_sram_data}, {16'd0, cap_d});
        end
      end else if (prev_w) begin
        check("strobe_length", 32'(slen), 32'(WC));
        check("done_after_strobe", {31'd0, o_done}, {31'd0, cur_last});
      end
      prev_w = o_sram_writing;
    end
  end

  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      i_byte_valid = 1'b0;
      i_byte = 8'($urandom);
      @(negedge i_clk);
    end
    i_byte = b;
    i_byte_valid = 1'b1;
    n = 0;
    while (!o_byte_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL byte_accept_timeout: ready stayed 0, required 1");
    end
    @(negedge i_clk);
  endtask

  // Reference model: word k sits at address k and is {byte 2k+1, byte 2k}.
  task automatic push_word(input int k);
    exp_t e;
    e.addr = 20'(k);
    e.data = {frame_bytes[2*k+1], frame_bytes[2*k]};
    e.last = (k == NW - 1);
    exp_q.push_back(e);
  endtask

  task automatic load_frame(input int maxgap);
    for (int k = 0; k < NW; k++) begin
      push_word(k);
      send_byte(frame_bytes[2*k],   maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
      send_byte(frame_bytes[2*k+1], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!o_done && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("done_reached", {31'd0, o_done}, 32'd1);
    repeat (2) @(negedge i_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_seq(input logic [7:0] base);
    logic [7:0] b;
    b = base;
    for (int i = 0; i < 8; i++) begin
      frame_bytes[i] = b;
      b = b + 8'd1;
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    #2;
    check("rst_ready",   {31'd0, o_byte_ready},   32'd0);
    check("rst_writing", {31'd0, o_sram_writing}, 32'd0);
    check("rst_done",    {31'd0, o_done},         32'd0);
    check("rst_addr",    {12'd0, o_sram_addr},    32'd0);
    check("rst_data",    {16'd0, o_sram_data},    32'd0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Frame 1: 0x11..0x18 back-to-back.
    set_seq(8'h11);
    b2b = 1'b1;
    pulse_start();
    load_frame(0);
    wait_done();
    b2b = 1'b0;

    // Frame 2: same data with random valid gaps.
    pulse_start();
    load_frame(5);
    wait_done();

    // Frame 3: random data, i_start pulsed during word 2's strobe.
    for (int i = 0; i < 8; i++) frame_bytes[i] = 8'($urandom);
    pulse_start();
    fork
      load_frame(3);
      begin
        int n = 0;
        while (!(o_sram_writing && o_sram_addr == 20'd2) && n < 300) begin
          @(negedge i_clk);
          n++;
        end
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
      end
    join
    wait_done();

    // Frame 4: reset during word 1's strobe.
    for (int i = 0; i < 8; i++) frame_bytes[i] = 8'($urandom);
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      push_word(k);
      send_byte(frame_bytes[2*k], 0);
      send_byte(frame_bytes[2*k+1], 0);
    end
    i_byte_valid = 1'b0;
    check("pre_reset_in_strobe", {31'd0, o_sram_writing}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_writing", {31'd0, o_sram_writing}, 32'd0);
    check("async_rst_ready",   {31'd0, o_byte_ready},   32'd0);
    check("async_rst_done",    {31'd0, o_done},         32'd0);
    check("async_rst_addr",    {12'd0, o_sram_addr},    32'd0);
    check("async_rst_data",    {16'd0, o_sram_data},    32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    i_byte = 8'($urandom);
    i_byte_valid = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      check("idle_after_rst_ready", {31'd0, o_byte_ready}, 32'd0);
      check("idle_after_rst_addr",  {12'd0, o_sram_addr},  32'd0);
    end
    i_byte_valid = 1'b0;
    pulse_start();
    load_frame(2);
    wait_done();

    // Frame 5: rewrite from DONE with 0xA0..0xA7.
    set_seq(8'hA0);
    pulse_start();
    check("done_drops_on_restart", {31'd0, o_done}, 32'd0);
    load_frame(3);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_bg_loader.md
SRAM_BG_LOADER -- requirements
Module: sram_bg_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 307200, number of 16-bit SRAM words per background frame (640x480).
REQ-002 SHALL have parameter WRITE_CYCLES, default 2, clock cycles the write strobe is held per word (legal range 1..7).
REQ-003 SHALL have port i_clk  input  1  system clock.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  one-cycle pulse that begins a frame load.
REQ-006 SHALL have port i_byte  input  8  incoming background byte stream, e.g. from the serial receiver.
REQ-007 SHALL have port i_byte_valid  input  1  i_byte is valid this cycle.
REQ-008 SHALL have port o_byte_ready  output  1  loader accepts i_byte this cycle.
REQ-009 SHALL have port o_sram_writing  output  1  write in progress; top drives WE_N and SRAM address/data mux from it.
REQ-010 SHALL have port o_sram_addr  output  SRAM_ADDR_COUNT (20)  SRAM write address.
REQ-011 SHALL have port o_sram_data  output  SRAM_DATA_WIDTH (16)  SRAM write data.
REQ-012 SHALL have port o_done  output  1  full frame written; level signal.

Function
REQ-013 SHALL implement states IDLE, LO, HI, WRITE, DONE.
REQ-014 IDLE: o_byte_ready=0; i_start -> LO, word counter and address cleared to 0.
REQ-015 LO: o_byte_ready=1; a byte transfers only when i_byte_valid && o_byte_ready in the same cycle; the byte goes to data[7:0]; then -> HI.
REQ-016 HI: o_byte_ready=1; on transfer the byte goes to data[15:8]; then -> WRITE.
REQ-017 WRITE: o_byte_ready=0, o_sram_writing=1 for exactly WRITE_CYCLES consecutive cycles; addr and data stay stable for the whole strobe.
REQ-018 At the end of WRITE: the address increments by 1 and the word count increments by 1; if the count equals NUM_WORDS -> DONE, else -> LO.
REQ-019 Back-to-back valid bytes: each word takes 2+WRITE_CYCLES cycles with no lost or duplicated bytes.
REQ-020 o_sram_writing SHALL be 0 in every state other than WRITE, so the frame decoder owns the SRAM.
REQ-021 DONE: o_done=1, o_byte_ready=0; i_start re-arms to LO with addr/count cleared and o_done drops the next cycle.
REQ-022 i_start in LO, HI or WRITE is ignored; the load in progress continues unchanged.
REQ-023 Address is 20-bit unsigned and never exceeds NUM_WORDS-1 while writing; no wrap occurs.
REQ-024 i_byte_valid held without a transfer (ready low) SHALL NOT be consumed.

Reset
REQ-025 Reset asserted (including mid-load) SHALL force, asynchronously: state=IDLE, o_sram_writing=0, o_byte_ready=0, o_done=0, o_sram_addr=0, o_sram_data=0, counter=0.
REQ-026 After reset is released, nothing happens until the next i_start; a partial frame is not resumed.

Structure
REQ-027 SRAM_ADDR_COUNT, SRAM_DATA_WIDTH and the default frame size SHALL come from sram_pkg; the state enum type loader_state_t SHALL be declared in sram_pkg.
REQ-028 The block is one flat module with no sub-modules; the strobe timer is an internal 3-bit counter.

Verification
REQ-029 NUM_WORDS=4, WRITE_CYCLES=2; send bytes 0x11..0x18 back-to-back -> writes (addr,data) = (0,0x1211), (1,0x1413), (2,0x1615), (3,0x1817); each strobe lasts 2 cycles; o_done rises 1 cycle after the last strobe.
REQ-030 Random valid gaps (valid low 0-5 cycles) with the same data -> identical write sequence and no extra strobes.
REQ-031 i_start pulsed during word 2's WRITE -> the sequence is unaffected and o_done asserts after word 3.
REQ-032 Reset asserted mid-strobe at word 1 -> o_sram_writing=0 immediately (asynchronous), all outputs 0; a new i_start reloads from addr 0.
REQ-033 After DONE, i_start plus 8 new bytes 0xA0..0xA7 -> the frame is rewritten from addr 0 (0xA1A0 first); o_done deasserts during the load.
REQ-034 An assertion SHALL check that o_sram_writing is never 1 while o_byte_ready=1, and that addr/data are stable during every strobe.
